// File: rtl/fwrisc_csr_seq_if.sv
// rtl/fwrisc_csr_seq_if.sv - request and register-file port bundle for the CSR sequencer
interface fwrisc_csr_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_imm;
    logic [5:0]  req_csr;
    logic [4:0]  req_rs1;
    logic [4:0]  req_zimm;
    logic [4:0]  req_rd;
    logic [5:0]  ra_raddr;
    logic [31:0] ra_rdata;
    logic [5:0]  rb_raddr;
    logic [31:0] rb_rdata;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic        done;
    logic        illegal;

    modport master (
        output req_valid, req_op, req_imm, req_csr, req_rs1, req_zimm, req_rd,
        output ra_rdata, rb_rdata,
        input  req_ready, ra_raddr, rb_raddr, rd_waddr, rd_wdata, rd_wen, done, illegal
    );

    modport slave (
        input  req_valid, req_op, req_imm, req_csr, req_rs1, req_zimm, req_rd,
        input  ra_rdata, rb_rdata,
        output req_ready, ra_raddr, rb_raddr, rd_waddr, rd_wdata, rd_wen, done, illegal
    );
endinterface

// File: rtl/fwrisc_csr_seq.sv
// rtl/fwrisc_csr_seq.sv - Zicsr read-modify-write sequencer driving the fwrisc register file
module fwrisc_csr_seq #(
    parameter logic [63:0] RO_MASK = 64'h0
) (
    input  logic            clock,
    input  logic            reset,
    fwrisc_csr_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, CALC, WR_CSR, WR_GPR, DONE} state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    state_t      state;
    logic [1:0]  op_q;
    logic        imm_q;
    logic [5:0]  csr_q;
    logic [4:0]  zimm_q;
    logic [4:0]  rd_q;
    logic        wcsr_q;
    logic [31:0] old_q;

    logic        ready_q;
    logic [5:0]  ra_q;
    logic [5:0]  rb_q;
    logic [5:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        wen_q;
    logic        done_q;
    logic        illegal_q;

    logic        wcsr_in;
    logic        illegal_in;
    logic [31:0] src_val;
    logic [31:0] new_val;

    // RS/RC with a zero operand is a pure read, so read-only CSRs stay legal for it
    always_comb begin
        wcsr_in = 1'b1;
        if (bus.req_op != OP_RW)
            wcsr_in = bus.req_imm ? (bus.req_zimm != 5'd0) : (bus.req_rs1 != 5'd0);
        illegal_in = (bus.req_op == 2'b00) || !bus.req_csr[5] ||
                     (wcsr_in && RO_MASK[bus.req_csr]);
    end

    always_comb begin
        src_val = imm_q ? {27'b0, zimm_q} : bus.ra_rdata;
        case (op_q)
            OP_RW:   new_val = src_val;
            OP_RS:   new_val = bus.rb_rdata | src_val;
            default: new_val = bus.rb_rdata & ~src_val;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= 2'b00;
            imm_q     <= 1'b0;
            csr_q     <= 6'd0;
            zimm_q    <= 5'd0;
            rd_q      <= 5'd0;
            wcsr_q    <= 1'b0;
            old_q     <= 32'd0;
            ready_q   <= 1'b0;
            ra_q      <= 6'd0;
            rb_q      <= 6'd0;
            waddr_q   <= 6'd0;
            wdata_q   <= 32'd0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        op_q    <= bus.req_op;
                        imm_q   <= bus.req_imm;
                        csr_q   <= bus.req_csr;
                        zimm_q  <= bus.req_zimm;
                        rd_q    <= bus.req_rd;
                        wcsr_q  <= wcsr_in;
                        if (illegal_in) begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else begin
                            state <= READ;
                            ra_q  <= {1'b0, bus.req_rs1};
                            rb_q  <= bus.req_csr;
                        end
                    end
                end
                READ: begin
                    state <= CALC;
                    ra_q  <= 6'd0;
                    rb_q  <= 6'd0;
                end
                CALC: begin
                    // src is captured here, so rd==rs1 cannot corrupt the CSR value
                    old_q <= bus.rb_rdata;
                    if (wcsr_q) begin
                        state   <= WR_CSR;
                        wen_q   <= 1'b1;
                        waddr_q <= csr_q;
                        wdata_q <= new_val;
                    end else if (rd_q != 5'd0) begin
                        state   <= WR_GPR;
                        wen_q   <= 1'b1;
                        waddr_q <= {1'b0, rd_q};
                        wdata_q <= bus.rb_rdata;
                    end else begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                WR_CSR: begin
                    if (rd_q != 5'd0) begin
                        state   <= WR_GPR;
                        waddr_q <= {1'b0, rd_q};
                        wdata_q <= old_q;
                    end else begin
                        state   <= DONE;
                        wen_q   <= 1'b0;
                        waddr_q <= 6'd0;
                        wdata_q <= 32'd0;
                        done_q  <= 1'b1;
                    end
                end
                WR_GPR: begin
                    state   <= DONE;
                    wen_q   <= 1'b0;
                    waddr_q <= 6'd0;
                    wdata_q <= 32'd0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.ra_raddr  = ra_q;
    assign bus.rb_raddr  = rb_q;
    assign bus.rd_waddr  = waddr_q;
    assign bus.rd_wdata  = wdata_q;
    assign bus.rd_wen    = wen_q;
    assign bus.done      = done_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_fwrisc_csr_seq.sv
// tb/tb_fwrisc_csr_seq.sv - directed self-checking bench for fwrisc_csr_seq
module tb_fwrisc_csr_seq;
    localparam logic [5:0] CSR_MSTATUS  = 6'h20;
    localparam logic [5:0] CSR_MIP      = 6'h24;
    localparam logic [5:0] CSR_MTVEC    = 6'h25;
    localparam logic [5:0] CSR_MSCRATCH = 6'h30;
    localparam logic [5:0] CSR_MHARTID  = 6'h3F;
    localparam logic [63:0] RO_MASK = (64'h1 << CSR_MHARTID) | (64'h1 << CSR_MIP);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    logic [31:0] rf [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [31:0] pre_data = 32'd0;

    fwrisc_csr_seq_if bus ();

    fwrisc_csr_seq #(.RO_MASK(RO_MASK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // register file model: registered reads, one write port, plus a bench preload port
    always @(posedge clock) begin
        bus.ra_rdata <= rf[bus.ra_raddr];
        bus.rb_rdata <= rf[bus.rb_raddr];
        if (pre_en)
            rf[pre_addr] <= pre_data;
        else if (bus.rd_wen === 1'b1)
            rf[bus.rd_waddr] <= bus.rd_wdata;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic wen, input logic [5:0] waddr,
                         input logic [31:0] wdata);
        chk({tag, ".wen"}, {31'b0, bus.rd_wen}, {31'b0, wen});
        chk({tag, ".waddr"}, {26'b0, bus.rd_waddr}, {26'b0, waddr});
        chk({tag, ".wdata"}, bus.rd_wdata, wdata);
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic req(input logic [1:0] op, input logic imm, input logic [5:0] csr,
                       input logic [4:0] rs1, input logic [4:0] zimm, input logic [4:0] rd);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_imm = imm; bus.req_csr = csr;
        bus.req_rs1 = rs1; bus.req_zimm = zimm; bus.req_rd = rd;
    endtask

    // writes to x0 must never reach the register file
    always @(negedge clock) begin
        if (!reset && bus.rd_wen === 1'b1) begin
            compared++;
            assert (bus.rd_waddr !== 6'd0) else begin
                mismatched++;
                $error("FAIL wen_x0: observed waddr %h expected nonzero", bus.rd_waddr);
            end
        end
    end

    logic [1:0] ill_op  [3];
    logic [5:0] ill_csr [3];

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_imm = 1'b0; bus.req_csr = 6'd0;
        bus.req_rs1 = 5'd0; bus.req_zimm = 5'd0; bus.req_rd = 5'd0;
        for (int i = 0; i < 64; i++) rf[i] = 32'd0;
        @(negedge clock);

        preload(6'd5, 32'h8000_0100);
        preload(CSR_MTVEC, 32'h0);
        preload(CSR_MSTATUS, 32'h0000_0008);
        preload(CSR_MHARTID, 32'h0000_1234);
        preload(CSR_MSCRATCH, 32'hCAFE_0000);
        chk("rst.ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst.done", {31'b0, bus.done}, 32'd0);
        chk("rst.illegal", {31'b0, bus.illegal}, 32'd0);
        chk("rst.ra", {26'b0, bus.ra_raddr}, 32'd0);
        chk("rst.rb", {26'b0, bus.rb_raddr}, 32'd0);
        chk_w("rst", 1'b0, 6'd0, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst.ready", {31'b0, bus.req_ready}, 32'd1);

        // CSRRW mtvec, x5 -> x6
        req(2'b01, 1'b0, CSR_MTVEC, 5'd5, 5'd0, 5'd6);
        tick();
        bus.req_valid = 1'b0;
        chk("rw.ra", {26'b0, bus.ra_raddr}, 32'd5);
        chk("rw.rb", {26'b0, bus.rb_raddr}, {26'b0, CSR_MTVEC});
        chk("rw.ready_busy", {31'b0, bus.req_ready}, 32'd0);
        tick(); chk_w("rw.calc", 1'b0, 6'd0, 32'd0);
        tick(); chk_w("rw.wcsr", 1'b1, CSR_MTVEC, 32'h8000_0100);
        tick(); chk_w("rw.wgpr", 1'b1, 6'd6, 32'h0);
        tick(); chk("rw.done", {31'b0, bus.done}, 32'd1);
        chk("rw.illegal", {31'b0, bus.illegal}, 32'd0);
        chk_w("rw.idle", 1'b0, 6'd0, 32'd0);
        tick(); chk("rw.ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rw.done_off", {31'b0, bus.done}, 32'd0);

        // CSRRS mstatus, x0 -> x7: read only
        req(2'b10, 1'b0, CSR_MSTATUS, 5'd0, 5'd0, 5'd7);
        tick();
        bus.req_valid = 1'b0;
        tick(); chk_w("rs0.calc", 1'b0, 6'd0, 32'd0);
        tick(); chk_w("rs0.wgpr", 1'b1, 6'd7, 32'h0000_0008);
        tick(); chk("rs0.done", {31'b0, bus.done}, 32'd1);
        chk_w("rs0.idle", 1'b0, 6'd0, 32'd0);
        tick();

        // CSRRCI mstatus, 8 -> x0
        preload(CSR_MSTATUS, 32'h0000_0088);
        req(2'b11, 1'b1, CSR_MSTATUS, 5'd0, 5'd8, 5'd0);
        tick();
        bus.req_valid = 1'b0;
        tick(); chk_w("rci.calc", 1'b0, 6'd0, 32'd0);
        tick(); chk_w("rci.wcsr", 1'b1, CSR_MSTATUS, 32'h0000_0080);
        tick(); chk("rci.done", {31'b0, bus.done}, 32'd1);
        chk_w("rci.nogpr", 1'b0, 6'd0, 32'd0);
        tick(); chk("rci.rf", rf[CSR_MSTATUS], 32'h0000_0080);

        // illegal: write to read-only mhartid, op 00, csr below 0x20
        ill_op[0] = 2'b01; ill_csr[0] = CSR_MHARTID;
        ill_op[1] = 2'b00; ill_csr[1] = 6'h21;
        ill_op[2] = 2'b01; ill_csr[2] = 6'h05;
        for (int i = 0; i < 3; i++) begin
            req(ill_op[i], 1'b0, ill_csr[i], 5'd1, 5'd0, 5'd3);
            tick();
            bus.req_valid = 1'b0;
            chk($sformatf("ill%0d.done", i), {31'b0, bus.done}, 32'd1);
            chk($sformatf("ill%0d.illegal", i), {31'b0, bus.illegal}, 32'd1);
            chk($sformatf("ill%0d.ra", i), {26'b0, bus.ra_raddr}, 32'd0);
            chk_w($sformatf("ill%0d", i), 1'b0, 6'd0, 32'd0);
            tick();
            chk($sformatf("ill%0d.ready", i), {31'b0, bus.req_ready}, 32'd1);
            chk($sformatf("ill%0d.clr", i), {30'b0, bus.done, bus.illegal}, 32'd0);
        end

        // CSRRS mhartid, x0 is a legal read of a read-only CSR
        req(2'b10, 1'b0, CSR_MHARTID, 5'd0, 5'd0, 5'd9);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick(); chk_w("hart.wgpr", 1'b1, 6'd9, 32'h0000_1234);
        tick(); chk("hart.done", {31'b0, bus.done}, 32'd1);
        chk("hart.illegal", {31'b0, bus.illegal}, 32'd0);
        tick();

        // reset in the middle of a CSRRW aborts it
        req(2'b01, 1'b0, CSR_MTVEC, 5'd5, 5'd0, 5'd6);
        tick();
        bus.req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_w("abort", 1'b0, 6'd0, 32'd0);
        chk("abort.done", {31'b0, bus.done}, 32'd0);
        chk("abort.ready", {31'b0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        tick();
        chk("abort.ready_after", {31'b0, bus.req_ready}, 32'd1);
        chk("abort.done_after", {31'b0, bus.done}, 32'd0);
        chk_w("abort.after", 1'b0, 6'd0, 32'd0);

        // CSRRSI mtvec, 3 -> x6 after the abort
        req(2'b10, 1'b1, CSR_MTVEC, 5'd0, 5'd3, 5'd6);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick(); chk_w("rsi.wcsr", 1'b1, CSR_MTVEC, 32'h8000_0103);
        tick(); chk_w("rsi.wgpr", 1'b1, 6'd6, 32'h8000_0100);
        tick(); chk("rsi.done", {31'b0, bus.done}, 32'd1);
        tick();

        // back-to-back CSRRW mscratch, x5 -> x8 with req_valid held
        req(2'b01, 1'b0, CSR_MSCRATCH, 5'd5, 5'd0, 5'd8);
        tick(); tick();
        tick(); chk_w("b2b1.wcsr", 1'b1, CSR_MSCRATCH, 32'h8000_0100);
        tick(); chk_w("b2b1.wgpr", 1'b1, 6'd8, 32'hCAFE_0000);
        tick(); chk("b2b1.done", {31'b0, bus.done}, 32'd1);
        tick(); chk("b2b.ready", {31'b0, bus.req_ready}, 32'd1);
        chk_w("b2b.gap", 1'b0, 6'd0, 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b2.ready", {31'b0, bus.req_ready}, 32'd0);
        chk("b2b2.ra", {26'b0, bus.ra_raddr}, 32'd5);
        tick();
        tick(); chk_w("b2b2.wcsr", 1'b1, CSR_MSCRATCH, 32'h8000_0100);
        tick(); chk_w("b2b2.wgpr", 1'b1, 6'd8, 32'h8000_0100);
        tick(); chk("b2b2.done", {31'b0, bus.done}, 32'd1);
        tick(); chk("b2b2.ready_end", {31'b0, bus.req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fwrisc_csr_seq.md
# fwrisc_csr_seq

CSR read-modify-write sequencer placed directly upstream of the fwrisc register file. It accepts one decoded Zicsr instruction (CSRRW/CSRRS/CSRRC and immediate forms) and drives the register file's A/B read ports and single write port. It reads rs1 and the CSR, computes the new CSR value, writes the CSR, then writes the old CSR value to the destination GPR. Completion or an illegal-instruction flag is reported to the core.

## Interface
Parameters:
- RO_MASK, 64'h0 | bit n set: regfile index n is read-only. The integration sets the CSR_MHARTID and CSR_MIP bits.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request strobe
- req_ready  out  1  block can accept a request
- req_op  in  2  01 RW, 10 RS, 11 RC; 00 is illegal
- req_imm  in  1  1 selects the zero-extended req_zimm as the source operand instead of rs1
- req_csr  in  6  regfile index of the CSR; valid range 0x20–0x3F
- req_rs1  in  5  source GPR
- req_zimm  in  5  immediate operand
- req_rd  in  5  destination GPR
- ra_raddr  out  6  to regfile A port
- ra_rdata  in  32  from regfile, registered one cycle
- rb_raddr  out  6  to regfile B port
- rb_rdata  in  32  from regfile, registered one cycle
- rd_waddr  out  6  regfile write address
- rd_wdata  out  32  regfile write data
- rd_wen  out  1  regfile write enable
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; 1 means the request was illegal

## Operation
- States: IDLE, READ, CALC, WR_CSR, WR_GPR, DONE.
- **Accept:** in IDLE, req_ready=1. When req_valid is high, latch all req_* fields.
- **Illegal check:** a request is illegal if any of these hold:
  - req_op==00
  - req_csr[5]==0
  - the CSR write is enabled and RO_MASK[req_csr] is set
- **Routing after accept:** an illegal request goes to DONE with illegal=1 and performs no reads or writes. A legal request goes to READ.
- **CSR write enable (wcsr):** 1 for RW. For RS/RC, 1 only when the operand source is nonzero: rs1 index !=0, or zimm !=0 when req_imm=1.
- **READ:** ra_raddr={1'b0,rs1}, rb_raddr=csr.
- **CALC:** sample the operands.
  - src = req_imm ? {27'b0,zimm} : ra_rdata
  - old = rb_rdata
  - new = RW: src; RS: old|src; RC: old&~src
  - Store old and new in internal registers.
  - Next state: WR_CSR if wcsr, else WR_GPR if rd!=0, else DONE.
- **WR_CSR:** rd_wen=1, rd_waddr=csr, rd_wdata=new. Next: WR_GPR if rd!=0, else DONE.
- **WR_GPR:** rd_wen=1, rd_waddr={1'b0,rd}, rd_wdata=old. Next: DONE.
- **DONE:** done=1 for one cycle, then IDLE.
- **Write ordering:** the CSR write always precedes the GPR write. rd==rs1 is safe because src is latched in CALC.
- **Write suppression:** rd_wen is never asserted with rd_waddr==0.
- **Idle outputs:** ra_raddr, rb_raddr, rd_waddr and rd_wdata are 0 outside their active states.

## Timing
- Accept edge is T0.
- Legal request, both writes: READ at T0+1, CALC at T0+2, WR_CSR at T0+3, WR_GPR at T0+4, done at T0+5.
- Each skipped write removes one cycle. Minimum legal latency is done at T0+3 (no writes).
- Illegal request: done=1, illegal=1 at T0+1.
- req_ready is 0 from T0+1 through the DONE cycle. A new request can be accepted the cycle after done.
- **Reset behaviour:** while reset is high:
  - state goes to IDLE
  - req_ready=0; rd_wen=0, done=0, illegal=0
  - all address/data outputs are 0
- **After reset:** req_ready=1 in the first cycle after reset deasserts.
- **Reset mid-operation:** the request is aborted. No further writes occur and no done pulse is produced.
- **Counter CSRs:** a read of CSR_MCYCLE returns the value registered at the end of READ.

## Test plan
- CSRRW csr=CSR_MTVEC, rs1=x5=0x8000_0100, rd=x6, MTVEC=0x0 → MTVEC write 0x8000_0100 at T0+3; x6 write 0x0 at T0+4; done at T0+5, illegal=0.
- CSRRS on CSR_MSTATUS with rs1=x0, rd=x7 (mie=1) → no CSR write; x7 write 0x0000_0008 at T0+3; done at T0+4.
- CSRRCI on CSR_MSTATUS, zimm=8, rd=x0, MSTATUS=0x88 → MSTATUS write 0x80 at T0+3; no GPR write; done at T0+4.
- CSRRW on CSR_MHARTID (RO_MASK set), req_op=00, and req_csr=0x05 → each gives done+illegal at T0+1 with rd_wen never asserted.
- Reset asserted at T0+3 of a CSRRW → rd_wen=0 in that cycle, no done; req_ready=1 the cycle after reset drops; the next request completes normally.
- Back-to-back requests with req_valid held high → second accepted the cycle after the first done; writes never overlap.
